// File: rtl/clock_set_controller_pkg.sv
// Shared types and field constants for the clock time chain.
// Mode encoding is also what appears on the mode output.
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_MIN  = 2'd1,
        SET_HOUR = 2'd2
    } mode_e;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 4;

    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
    localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

    // Next state of the mode ring; the unused code falls back to RUN.
    function automatic logic [1:0] nextMode(input logic [1:0] cur);
        logic [1:0] nxt;
        nxt = RUN;
        case (cur)
            RUN:      nxt = SET_MIN;
            SET_MIN:  nxt = SET_HOUR;
            SET_HOUR: nxt = RUN;
            default:  nxt = RUN;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/clock_set_controller_if.sv
// Button inputs and time/display outputs of the clock set controller.
// master = board/button side, slave = controller.
interface clock_set_if;
    import clock_ctrl_pkg::*;

    logic              modeBtn;
    logic              incBtn;
    logic              secondTick;
    logic              minuteTick;
    logic              hourTick;
    logic [SEC_W-1:0]  seconds;
    logic [MIN_W-1:0]  minutes;
    logic [HOUR_W-1:0] hours;
    logic [1:0]        mode;
    logic              blink;

    modport master (
        output modeBtn, incBtn,
        input  secondTick, minuteTick, hourTick, seconds, minutes, hours, mode, blink
    );

    modport slave (
        input  modeBtn, incBtn,
        output secondTick, minuteTick, hourTick, seconds, minutes, hours, mode, blink
    );

endinterface

// File: rtl/clock_set_controller_tick.sv
// Free-running divider producing a 1 Hz tick and a 2 Hz half tick.
// clear restarts the second so the next tick is a full CLK_DIV cycles away.
module tick_prescaler #(
    parameter int CLK_DIV = 100000000
) (
    input  logic clock,
    input  logic resetN,
    input  logic clear,
    output logic tickPulse,
    output logic halfPulse
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLK_DIV / 2 - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock) begin
        if (!resetN || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tickPulse = (count == LAST);
    assign halfPulse = (count == HALF) || (count == LAST);

endmodule

// File: rtl/clock_set_controller.sv
// Time-chain sequencer: 1 Hz seconds/minutes/hours with carry, plus a
// two-button mode FSM for setting minutes and hours.
//
// state    | meaning
// ST_RUN   | time advances on each 1 Hz tick, tick pulses issued
// ST_SETM  | seconds held at 0, incBtn bumps minutes (no carry), field blinks
// ST_SETH  | incBtn bumps hours, field blinks
module clock_set_controller
    import clock_ctrl_pkg::*;
#(
    parameter int CLK_DIV  = 100000000,
    parameter int HOUR_MAX = 11
) (
    input  logic        clock,
    input  logic        resetN,
    clock_set_if.slave  bus
);

    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_SETM = SET_MIN;
    localparam logic [1:0] ST_SETH = SET_HOUR;

    localparam logic [HOUR_W-1:0] HOUR_LAST = HOUR_W'(HOUR_MAX);

    logic [1:0]        modeQ;
    logic [1:0]        modeNext;
    logic [SEC_W-1:0]  secQ;
    logic [MIN_W-1:0]  minQ;
    logic [HOUR_W-1:0] hourQ;
    logic              secTickQ;
    logic              minTickQ;
    logic              hourTickQ;
    logic              blinkQ;

    logic tickPulse;
    logic halfPulse;
    logic prescClear;
    logic runTick;
    logic secWrap;
    logic minWrap;
    logic hourWrap;

    assign modeNext = nextMode(modeQ);
    assign runTick  = (modeQ == ST_RUN) && tickPulse;
    assign secWrap  = (secQ == SEC_MAX);
    assign minWrap  = (minQ == MIN_MAX);
    assign hourWrap = (hourQ == HOUR_LAST);

    // Restart the second on entering SET_MIN and on returning to RUN.
    assign prescClear = bus.modeBtn && (modeQ != ST_SETM);

    tick_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) uPrescaler (
        .clock     (clock),
        .resetN    (resetN),
        .clear     (prescClear),
        .tickPulse (tickPulse),
        .halfPulse (halfPulse)
    );

    always_ff @(posedge clock) begin
        if (!resetN) begin
            modeQ     <= ST_RUN;
            secQ      <= '0;
            minQ      <= '0;
            hourQ     <= '0;
            secTickQ  <= 1'b0;
            minTickQ  <= 1'b0;
            hourTickQ <= 1'b0;
            blinkQ    <= 1'b0;
        end else begin
            secTickQ  <= 1'b0;
            minTickQ  <= 1'b0;
            hourTickQ <= 1'b0;

            if (runTick) begin
                secTickQ <= 1'b1;
                secQ     <= secWrap ? '0 : secQ + 1'b1;
                if (secWrap) begin
                    minTickQ <= 1'b1;
                    minQ     <= minWrap ? '0 : minQ + 1'b1;
                    if (minWrap) begin
                        hourTickQ <= 1'b1;
                        hourQ     <= hourWrap ? '0 : hourQ + 1'b1;
                    end
                end
            end

            // A tick coinciding with entry to SET_MIN still carries, but seconds end at 0.
            if (bus.modeBtn) begin
                modeQ  <= modeNext;
                blinkQ <= 1'b0;
                if (modeNext == ST_SETM) begin
                    secQ <= '0;
                end
            end else begin
                case (modeQ)
                    ST_SETM: begin
                        if (bus.incBtn) begin
                            minQ <= minWrap ? '0 : minQ + 1'b1;
                        end
                        if (halfPulse) begin
                            blinkQ <= ~blinkQ;
                        end
                    end
                    ST_SETH: begin
                        if (bus.incBtn) begin
                            hourQ <= hourWrap ? '0 : hourQ + 1'b1;
                        end
                        if (halfPulse) begin
                            blinkQ <= ~blinkQ;
                        end
                    end
                    default: begin
                        blinkQ <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.secondTick = secTickQ;
    assign bus.minuteTick = minTickQ;
    assign bus.hourTick   = hourTickQ;
    assign bus.seconds    = secQ;
    assign bus.minutes    = minQ;
    assign bus.hours      = hourQ;
    assign bus.mode       = modeQ;
    assign bus.blink      = blinkQ;

endmodule
